operand_stage: RTL and testbench
================================

Name: operand_stage

Overview:
- ID/EX operand stage directly downstream of the register file.
- Drives register read addresses from the decoded instruction and receives the read ports.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and inserts load-use bubbles.
- Holds a valid/ready pipeline register that feeds the EX stage, with flush support.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 5, register address width (32 registers, $0 hard-wired zero).
- CTRL_W, 16, opaque decoded control bundle passed through to EX.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  decode presents an instruction.
- id_rs, id_rt  in  ADDR_W  source registers.
- id_use_rs, id_use_rt  in  1  source actually read by the instruction.
- id_rd  in  ADDR_W  destination register.
- id_we  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a load.
- id_ctrl  in  CTRL_W  control bundle.
- id_stall  out  1  decode must hold its instruction this cycle.
- RA, RB  out  ADDR_W  register file read addresses; combinational copies of id_rs and id_rt.
- PA, PB  in  DATA_W  register file read data.
- ex_result  in  DATA_W  combinational ALU result of the instruction currently held in EX.
- mem_rd  in  ADDR_W  MEM stage destination.
- mem_we  in  1  MEM stage write enable.
- mem_data  in  DATA_W  MEM stage result, load data included.
- wb_rd  in  ADDR_W  WB destination; equals the register file RW.
- wb_we  in  1  WB write enable; equals the register file LE.
- wb_data  in  DATA_W  WB data; equals the register file PW.
- flush  in  1  kill the ID and EX-bound instruction (taken branch).
- ex_ready  in  1  EX accepts a new instruction this cycle.
- ex_valid  out  1  EX-bound register holds a valid instruction.
- ex_a, ex_b  out  DATA_W  resolved operands.
- ex_rd  out  ADDR_W  destination, registered.
- ex_we  out  1  write enable, registered.
- ex_is_load  out  1  load flag, registered.
- ex_ctrl  out  CTRL_W  control bundle, registered.

Behaviour:
- Reset: on rst_n=0 at a rising clk edge, all registered outputs clear to 0 (ex_valid, ex_a, ex_b, ex_rd, ex_we, ex_is_load, ex_ctrl). id_stall is combinational and depends only on current inputs.
- Forwarding, per source operand, priority high to low:
  - EX: ex_valid & ex_we & ~ex_is_load & ex_rd==src → ex_result.
  - MEM: mem_we & mem_rd==src → mem_data.
  - WB: wb_we & wb_rd==src → wb_data. The register file writes at the edge, so the same-cycle read returns the stale value.
  - Otherwise PA or PB.
  - src==0 always yields 0; no forwarding and no hazard.
- Load-use hazard: hz = id_valid & ex_valid & ex_is_load & ex_we & ex_rd!=0 & ((id_use_rs & ex_rd==id_rs) | (id_use_rt & ex_rd==id_rt)).
- Per-cycle priority at the edge, first match wins:
  1. flush=1: ex_valid<=0; id_stall=0 (decode discards its instruction); other fields don't-care.
  2. ex_ready=0: all registers hold; id_stall=id_valid.
  3. hz=1: ex_valid<=0 (bubble); id_stall=1. The load advances to MEM, so the next cycle forwards from MEM. Exactly one bubble per load-use.
  4. Otherwise: capture id_* and the resolved operands; ex_valid<=id_valid; id_stall=0.
- Latency: one cycle from id_valid (no stall) to ex_valid.
- A held instruction keeps its captured operands; they are not re-forwarded while held.
- Simultaneous flush and hz: flush wins, no bubble is counted.

Optional Feature:
- Macro OPSTAGE_PERF_EN.
- When defined: adds two 32-bit outputs.
  - perf_bubbles: increments on each rule-3 cycle.
  - perf_holds: increments on each rule-2 cycle with id_valid=1.
  - Both saturate at all ones and clear on reset.
- When undefined: neither port nor counter logic exists.

Decomposition:
- Shared pipeline_pkg holds: DATA_W, ADDR_W, CTRL_W constants, and the forward-select enum fwd_sel_t = {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}.
- Sub-module operand_forward: one source's comparators, select and data mux; instantiated twice (rs and rt).

Test Plan:
- Reset: hold rst_n=0 for 2 edges with id_valid=1 → ex_valid=0, ex_a=0, ex_b=0; release → first capture on the next edge.
- EX forwarding: add $3 captured, then next cycle id_rs=3 while ex_result=0x55 and PA=0x11 → ex_a=0x55; with mem_rd=3 and mem_data=0x66 also present → still 0x55.
- WB forwarding: wb_we=1, wb_rd=7, wb_data=0x1234, PB=0 (stale), id_rt=7 → ex_b=0x1234. With id_rt=0 and wb_rd=0 → ex_b=0.
- Load-use: lw $5 in EX, id_rs=5, id_use_rs=1 → id_stall=1 and ex_valid=0 for exactly one cycle. Next cycle mem_rd=5, mem_data=0xABCD → ex_a=0xABCD. With id_use_rs=0 → no stall.
- Backpressure: ex_ready=0 for 3 cycles → ex_* stable and id_stall=1 throughout; on ex_ready=1 the held decode instruction is captured.
- Flush: flush=1 while hz=1 and ex_ready=0 → next edge ex_valid=0, id_stall=0; with OPSTAGE_PERF_EN, perf_bubbles unchanged.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the operand forward-select encoding.
// Pure declarations; no timing or flow control.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CTRL_W = 16;
    localparam int PERF_W = 32;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_WB
    } fwd_sel_t;

endpackage

// File: rtl/operand_stage_if.sv
// Operand stage bus: decode/regfile/bypass inputs and EX-bound outputs; master is the surrounding pipeline, slave is operand_stage.
// With OPSTAGE_PERF_EN defined, the bus also carries the two performance counters.
interface operand_stage_if #(
    parameter int DW = pipeline_pkg::DATA_W,
    parameter int AW = pipeline_pkg::ADDR_W,
    parameter int CW = pipeline_pkg::CTRL_W
) ();

    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [AW-1:0] id_rd;
    logic          id_we;
    logic          id_is_load;
    logic [CW-1:0] id_ctrl;
    logic          id_stall;
    logic [AW-1:0] RA;
    logic [AW-1:0] RB;
    logic [DW-1:0] PA;
    logic [DW-1:0] PB;
    logic [DW-1:0] ex_result;
    logic [AW-1:0] mem_rd;
    logic          mem_we;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] wb_rd;
    logic          wb_we;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          ex_ready;
    logic          ex_valid;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [AW-1:0] ex_rd;
    logic          ex_we;
    logic          ex_is_load;
    logic [CW-1:0] ex_ctrl;
`ifdef OPSTAGE_PERF_EN
    logic [pipeline_pkg::PERF_W-1:0] perf_bubbles;
    logic [pipeline_pkg::PERF_W-1:0] perf_holds;
`endif

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_we, id_is_load, id_ctrl,
        output PA, PB, ex_result, mem_rd, mem_we, mem_data, wb_rd, wb_we, wb_data, flush, ex_ready,
        input  id_stall, RA, RB, ex_valid, ex_a, ex_b, ex_rd, ex_we, ex_is_load, ex_ctrl
`ifdef OPSTAGE_PERF_EN
        , input perf_bubbles, perf_holds
`endif
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_we, id_is_load, id_ctrl,
        input  PA, PB, ex_result, mem_rd, mem_we, mem_data, wb_rd, wb_we, wb_data, flush, ex_ready,
        output id_stall, RA, RB, ex_valid, ex_a, ex_b, ex_rd, ex_we, ex_is_load, ex_ctrl
`ifdef OPSTAGE_PERF_EN
        , output perf_bubbles, perf_holds
`endif
    );

endinterface

// File: rtl/operand_forward.sv
// One source operand's bypass: compare against EX/MEM/WB destinations and mux the youngest match over the regfile read.
// Purely combinational; register $0 always resolves to zero.
module operand_forward
    import pipeline_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic [AW-1:0] src_i,
    input  logic [DW-1:0] rf_data_i,
    input  logic          ex_fwd_en_i,
    input  logic [AW-1:0] ex_rd_i,
    input  logic [DW-1:0] ex_data_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_rd_i,
    input  logic [DW-1:0] mem_data_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_rd_i,
    input  logic [DW-1:0] wb_data_i,
    output logic [DW-1:0] data_o
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_RF;
        if (src_i == '0)                          sel = FWD_RF;
        else if (ex_fwd_en_i && ex_rd_i == src_i) sel = FWD_EX;
        else if (mem_we_i && mem_rd_i == src_i)   sel = FWD_MEM;
        else if (wb_we_i && wb_rd_i == src_i)     sel = FWD_WB;
    end

    // WB still needs a bypass: the regfile write lands on the edge, so this cycle's read is stale.
    always_comb begin
        data_o = rf_data_i;
        case (sel)
            FWD_EX:  data_o = ex_data_i;
            FWD_MEM: data_o = mem_data_i;
            FWD_WB:  data_o = wb_data_i;
            default: data_o = rf_data_i;
        endcase
        if (src_i == '0) data_o = '0;
    end

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: forwards EX/MEM/WB results, inserts one load-use bubble, registers the EX-bound instruction (1-cycle latency).
// Holds everything and stalls decode while ex_ready=0; flush kills it. OPSTAGE_PERF_EN adds bubble/hold counters.
module operand_stage #(
    parameter int DATA_W = pipeline_pkg::DATA_W,
    parameter int ADDR_W = pipeline_pkg::ADDR_W,
    parameter int CTRL_W = pipeline_pkg::CTRL_W
) (
    input logic            clk,
    input logic            rst_n,
    operand_stage_if.slave bus
);

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;
    logic [ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic              ex_we_q, ex_we_d;
    logic              ex_is_load_q, ex_is_load_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0] fwd_a, fwd_b;
    logic              ex_fwd_en, hz, id_stall;

    assign bus.RA = bus.id_rs;
    assign bus.RB = bus.id_rt;

    // A load's data isn't ready in EX; that case is the load-use bubble below instead.
    assign ex_fwd_en = ex_valid_q & ex_we_q & ~ex_is_load_q;

    operand_forward #(.DW(DATA_W), .AW(ADDR_W)) u_fwd_rs (
        .src_i(bus.id_rs), .rf_data_i(bus.PA),
        .ex_fwd_en_i(ex_fwd_en), .ex_rd_i(ex_rd_q), .ex_data_i(bus.ex_result),
        .mem_we_i(bus.mem_we), .mem_rd_i(bus.mem_rd), .mem_data_i(bus.mem_data),
        .wb_we_i(bus.wb_we), .wb_rd_i(bus.wb_rd), .wb_data_i(bus.wb_data),
        .data_o(fwd_a)
    );

    operand_forward #(.DW(DATA_W), .AW(ADDR_W)) u_fwd_rt (
        .src_i(bus.id_rt), .rf_data_i(bus.PB),
        .ex_fwd_en_i(ex_fwd_en), .ex_rd_i(ex_rd_q), .ex_data_i(bus.ex_result),
        .mem_we_i(bus.mem_we), .mem_rd_i(bus.mem_rd), .mem_data_i(bus.mem_data),
        .wb_we_i(bus.wb_we), .wb_rd_i(bus.wb_rd), .wb_data_i(bus.wb_data),
        .data_o(fwd_b)
    );

    assign hz = bus.id_valid & ex_valid_q & ex_is_load_q & ex_we_q & (ex_rd_q != '0) &
                ((bus.id_use_rs & (ex_rd_q == bus.id_rs)) | (bus.id_use_rt & (ex_rd_q == bus.id_rt)));

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_rd_d      = ex_rd_q;
        ex_we_d      = ex_we_q;
        ex_is_load_d = ex_is_load_q;
        ex_ctrl_d    = ex_ctrl_q;
        id_stall     = 1'b0;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (!bus.ex_ready) begin
            id_stall = bus.id_valid;
        end else if (hz) begin
            ex_valid_d = 1'b0;
            id_stall   = 1'b1;
        end else begin
            ex_valid_d   = bus.id_valid;
            ex_a_d       = fwd_a;
            ex_b_d       = fwd_b;
            ex_rd_d      = bus.id_rd;
            ex_we_d      = bus.id_we;
            ex_is_load_d = bus.id_is_load;
            ex_ctrl_d    = bus.id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_rd_q      <= '0;
            ex_we_q      <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_ctrl_q    <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_rd_q      <= ex_rd_d;
            ex_we_q      <= ex_we_d;
            ex_is_load_q <= ex_is_load_d;
            ex_ctrl_q    <= ex_ctrl_d;
        end
    end

    assign bus.id_stall   = id_stall;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_a       = ex_a_q;
    assign bus.ex_b       = ex_b_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_we      = ex_we_q;
    assign bus.ex_is_load = ex_is_load_q;
    assign bus.ex_ctrl    = ex_ctrl_q;

`ifdef OPSTAGE_PERF_EN
    logic [pipeline_pkg::PERF_W-1:0] perf_bubbles_q, perf_holds_q;
    logic                            bubble_evt, hold_evt;

    assign bubble_evt = ~bus.flush & bus.ex_ready & hz;
    assign hold_evt   = ~bus.flush & ~bus.ex_ready & bus.id_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_bubbles_q <= '0;
            perf_holds_q   <= '0;
        end else begin
            if (bubble_evt && perf_bubbles_q != '1) perf_bubbles_q <= perf_bubbles_q + 1'b1;
            if (hold_evt && perf_holds_q != '1)     perf_holds_q   <= perf_holds_q + 1'b1;
        end
    end

    assign bus.perf_bubbles = perf_bubbles_q;
    assign bus.perf_holds   = perf_holds_q;
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios plus randomized traffic against a rule-level reference model.
module tb_operand_stage;
    import pipeline_pkg::*;

    localparam int VEC_W = 1 + 2 * DATA_W + ADDR_W + 2 + CTRL_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_stage_if bus ();

    operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the EX-bound register and counters.
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_a = '0, m_b = '0;
    logic [ADDR_W-1:0] m_rd = '0;
    logic              m_we = 1'b0, m_ld = 1'b0;
    logic [CTRL_W-1:0] m_ctrl = '0;
    logic [31:0]       m_bub = '0, m_hold = '0;

    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] src, input logic [DATA_W-1:0] rf);
        if (src == 0) return '0;
        if (m_valid && m_we && !m_ld && m_rd == src) return bus.ex_result;
        if (bus.mem_we && bus.mem_rd == src) return bus.mem_data;
        if (bus.wb_we && bus.wb_rd == src) return bus.wb_data;
        return rf;
    endfunction

    function automatic logic hazard();
        return bus.id_valid && m_valid && m_ld && m_we && m_rd != 0 &&
               ((bus.id_use_rs && m_rd == bus.id_rs) || (bus.id_use_rt && m_rd == bus.id_rt));
    endfunction

    function automatic logic model_stall();
        if (bus.flush) return 1'b0;
        if (!bus.ex_ready) return bus.id_valid;
        return hazard();
    endfunction

    // Payload fields only matter while the entry is valid.
    function automatic logic [VEC_W-1:0] mod_vec();
        if (!m_valid) return '0;
        return {m_valid, m_a, m_b, m_rd, m_we, m_ld, m_ctrl};
    endfunction

    function automatic logic [VEC_W-1:0] obs_vec();
        if (!m_valid) return {bus.ex_valid, {(VEC_W-1){1'b0}}};
        return {bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we, bus.ex_is_load, bus.ex_ctrl};
    endfunction

    task automatic cyc();
        logic              hz, fl, rdy, v, rs, we, ld;
        logic [DATA_W-1:0] na, nb;
        logic [ADDR_W-1:0] rd;
        logic [CTRL_W-1:0] ctl;
        hz = hazard();
        na = fwd(bus.id_rs, bus.PA);
        nb = fwd(bus.id_rt, bus.PB);
        fl = bus.flush; rdy = bus.ex_ready; v = bus.id_valid; rs = rst_n;
        rd = bus.id_rd; we = bus.id_we; ld = bus.id_is_load; ctl = bus.id_ctrl;
        @(posedge clk);
        if (!rs) begin
            m_valid = 0; m_a = '0; m_b = '0; m_rd = '0; m_we = 0; m_ld = 0; m_ctrl = '0;
            m_bub = '0; m_hold = '0;
        end else if (fl) begin
            m_valid = 0;
        end else if (!rdy) begin
            if (v && m_hold != 32'hFFFF_FFFF) m_hold = m_hold + 1;
        end else if (hz) begin
            m_valid = 0;
            if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
        end else begin
            m_valid = v; m_a = na; m_b = nb; m_rd = rd; m_we = we; m_ld = ld; m_ctrl = ctl;
        end
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.id_rd = '0; bus.id_we = 0; bus.id_is_load = 0; bus.id_ctrl = CTRL_W'($urandom);
        bus.PA = $urandom; bus.PB = $urandom; bus.ex_result = $urandom;
        bus.mem_rd = '0; bus.mem_we = 0; bus.mem_data = $urandom;
        bus.wb_rd = '0; bus.wb_we = 0; bus.wb_data = $urandom;
        bus.flush = 0; bus.ex_ready = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        bus.id_valid = 1; bus.id_rs = 5'd1; bus.id_use_rs = 1; bus.PA = 32'h77; bus.id_rd = 5'd4; bus.id_we = 1;
        repeat (2) begin
            cyc();
            checks++;
            if ({bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_rd, bus.ex_we, bus.ex_is_load, bus.ex_ctrl} !== '0) begin
                errors++;
                $display("FAIL reset_state got valid=%0b a=%h b=%h rd=%0d want all zero",
                         bus.ex_valid, bus.ex_a, bus.ex_b, bus.ex_rd);
            end
        end
        rst_n = 1;
        cyc();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'h77 || bus.ex_rd !== 5'd4) begin
            errors++;
            $display("FAIL reset_first_capture got valid=%0b a=%h rd=%0d want 1 00000077 4",
                     bus.ex_valid, bus.ex_a, bus.ex_rd);
        end
    endtask

    task automatic test_ex_forward();
        idle();
        bus.id_valid = 1; bus.id_rd = 5'd3; bus.id_we = 1; bus.id_rs = 5'd1; bus.id_rt = 5'd2;
        cyc();
        bus.id_rs = 5'd3; bus.id_use_rs = 1; bus.ex_result = 32'h55; bus.PA = 32'h11;
        #1;
        checks++;
        if (bus.id_stall !== 1'b0) begin
            errors++; $display("FAIL ex_fwd_stall got %0b want 0", bus.id_stall);
        end
        cyc();
        checks++;
        if (bus.ex_a !== 32'h55) begin
            errors++; $display("FAIL ex_fwd got %h want 00000055", bus.ex_a);
        end
        bus.ex_result = 32'h55; bus.mem_we = 1; bus.mem_rd = 5'd3; bus.mem_data = 32'h66;
        cyc();
        checks++;
        if (bus.ex_a !== 32'h55 || obs_vec() !== mod_vec()) begin
            errors++; $display("FAIL ex_over_mem got %h want 00000055", bus.ex_a);
        end
    endtask

    task automatic test_wb_forward();
        idle();
        bus.id_valid = 1; bus.id_rd = 5'd9; bus.id_we = 1;
        bus.wb_we = 1; bus.wb_rd = 5'd7; bus.wb_data = 32'h1234; bus.PB = 32'h0; bus.id_rt = 5'd7; bus.id_use_rt = 1;
        cyc();
        checks++;
        if (bus.ex_b !== 32'h1234) begin
            errors++; $display("FAIL wb_fwd got %h want 00001234", bus.ex_b);
        end
        bus.id_rt = 5'd0; bus.wb_rd = 5'd0; bus.PB = 32'h99; bus.mem_we = 1; bus.mem_rd = 5'd0; bus.mem_data = 32'h5;
        cyc();
        checks++;
        if (bus.ex_b !== 32'h0) begin
            errors++; $display("FAIL zero_reg got %h want 00000000", bus.ex_b);
        end
    endtask

    task automatic test_load_use();
        idle();
        bus.id_valid = 1; bus.id_rd = 5'd5; bus.id_we = 1; bus.id_is_load = 1;
        cyc();
        bus.id_is_load = 0; bus.id_rd = 5'd8; bus.id_rs = 5'd5; bus.id_use_rs = 1; bus.PA = 32'h0;
        #1;
        checks++;
        if (bus.id_stall !== 1'b1) begin
            errors++; $display("FAIL load_use_stall got %0b want 1", bus.id_stall);
        end
        cyc();
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL load_use_bubble got ex_valid=%0b want 0", bus.ex_valid);
        end
        bus.mem_we = 1; bus.mem_rd = 5'd5; bus.mem_data = 32'hABCD;
        #1;
        checks++;
        if (bus.id_stall !== 1'b0) begin
            errors++; $display("FAIL load_use_one_bubble got stall=%0b want 0", bus.id_stall);
        end
        cyc();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'hABCD) begin
            errors++; $display("FAIL load_use_mem_fwd got valid=%0b a=%h want 1 0000abcd", bus.ex_valid, bus.ex_a);
        end
        idle();
        bus.id_valid = 1; bus.id_rd = 5'd5; bus.id_we = 1; bus.id_is_load = 1;
        cyc();
        bus.id_is_load = 0; bus.id_rd = 5'd8; bus.id_rs = 5'd5; bus.id_use_rs = 0;
        #1;
        checks++;
        if (bus.id_stall !== 1'b0) begin
            errors++; $display("FAIL unused_src_stall got %0b want 0", bus.id_stall);
        end
        cyc();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd8) begin
            errors++; $display("FAIL unused_src_capture got valid=%0b rd=%0d want 1 8", bus.ex_valid, bus.ex_rd);
        end
    endtask

    task automatic test_backpressure();
        logic [VEC_W-1:0] held;
        idle();
        bus.id_valid = 1; bus.id_rd = 5'd10; bus.id_we = 1; bus.id_ctrl = 16'hBEEF;
        cyc();
        held = obs_vec();
        bus.ex_ready = 0; bus.id_rd = 5'd11; bus.id_ctrl = 16'h1357;
        repeat (3) begin
            #1;
            checks++;
            if (bus.id_stall !== 1'b1) begin
                errors++; $display("FAIL bp_stall got %0b want 1", bus.id_stall);
            end
            bus.ex_result = $urandom; bus.PA = $urandom;
            cyc();
            checks++;
            if (obs_vec() !== held || bus.ex_rd !== 5'd10 || bus.ex_ctrl !== 16'hBEEF) begin
                errors++; $display("FAIL bp_hold got rd=%0d ctrl=%h want 10 beef", bus.ex_rd, bus.ex_ctrl);
            end
        end
        bus.ex_ready = 1;
        #1;
        checks++;
        if (bus.id_stall !== 1'b0) begin
            errors++; $display("FAIL bp_release_stall got %0b want 0", bus.id_stall);
        end
        cyc();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd11 || bus.ex_ctrl !== 16'h1357) begin
            errors++; $display("FAIL bp_release_capture got valid=%0b rd=%0d ctrl=%h want 1 11 1357",
                               bus.ex_valid, bus.ex_rd, bus.ex_ctrl);
        end
`ifdef OPSTAGE_PERF_EN
        checks++;
        if (bus.perf_holds !== m_hold) begin
            errors++; $display("FAIL perf_holds got %0d want %0d", bus.perf_holds, m_hold);
        end
`endif
    endtask

    task automatic test_flush();
        idle();
        bus.id_valid = 1; bus.id_rd = 5'd6; bus.id_we = 1; bus.id_is_load = 1;
        cyc();
        bus.id_is_load = 0; bus.id_rd = 5'd2; bus.id_rt = 5'd6; bus.id_use_rt = 1;
        bus.flush = 1; bus.ex_ready = 0;
        #1;
        checks++;
        if (bus.id_stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall got %0b want 0", bus.id_stall);
        end
        cyc();
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL flush_kill got ex_valid=%0b want 0", bus.ex_valid);
        end
`ifdef OPSTAGE_PERF_EN
        checks++;
        if (bus.perf_bubbles !== m_bub || bus.perf_holds !== m_hold) begin
            errors++; $display("FAIL flush_perf got bub=%0d holds=%0d want %0d %0d",
                               bus.perf_bubbles, bus.perf_holds, m_bub, m_hold);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.id_valid   = ($urandom_range(0, 3) != 0);
            bus.id_rs      = ADDR_W'($urandom_range(0, 3));
            bus.id_rt      = ADDR_W'($urandom_range(0, 3));
            bus.id_use_rs  = $urandom_range(0, 1);
            bus.id_use_rt  = $urandom_range(0, 1);
            bus.id_rd      = ADDR_W'($urandom_range(0, 3));
            bus.id_we      = ($urandom_range(0, 3) != 0);
            bus.id_is_load = ($urandom_range(0, 2) == 0);
            bus.id_ctrl    = CTRL_W'($urandom);
            bus.PA = $urandom; bus.PB = $urandom; bus.ex_result = $urandom;
            bus.mem_rd = ADDR_W'($urandom_range(0, 3)); bus.mem_we = $urandom_range(0, 1); bus.mem_data = $urandom;
            bus.wb_rd  = ADDR_W'($urandom_range(0, 3)); bus.wb_we  = $urandom_range(0, 1); bus.wb_data  = $urandom;
            bus.ex_ready = ($urandom_range(0, 3) != 0);
            bus.flush    = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (bus.id_stall !== model_stall() || bus.RA !== bus.id_rs || bus.RB !== bus.id_rt) begin
                errors++; $display("FAIL rand_comb[%0d] got stall=%0b RA=%0d RB=%0d want %0b %0d %0d",
                                   i, bus.id_stall, bus.RA, bus.RB, model_stall(), bus.id_rs, bus.id_rt);
            end
            cyc();
            checks++;
            if (obs_vec() !== mod_vec()) begin
                errors++; $display("FAIL rand_ex[%0d] got %h want %h", i, obs_vec(), mod_vec());
            end
`ifdef OPSTAGE_PERF_EN
            checks++;
            if (bus.perf_bubbles !== m_bub || bus.perf_holds !== m_hold) begin
                errors++; $display("FAIL rand_perf[%0d] got %0d %0d want %0d %0d",
                                   i, bus.perf_bubbles, bus.perf_holds, m_bub, m_hold);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_wb_forward();
        test_load_use();
        test_backpressure();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
